// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - shared constants and types for the writeback stage
//
// Purpose: one-hot opcode bit positions, squash FSM state encoding and
//          PC step sizes shared by rv_writeback_v2 and rv_wb_squash_ctrl.
// Ports:   none (package).
package rv_pkg;

   // Bit positions within the 11-bit one-hot instruction class vector.
   localparam int OP_RTYPE  = 0;
   localparam int OP_ITYPE  = 1;
   localparam int OP_LOAD   = 2;
   localparam int OP_STORE  = 3;
   localparam int OP_BRANCH = 4;
   localparam int OP_JAL    = 5;
   localparam int OP_JALR   = 6;
   localparam int OP_LUI    = 7;
   localparam int OP_AUIPC  = 8;
   localparam int OP_SYSTEM = 9;
   localparam int OP_FENCE  = 10;
   localparam int OP_W      = 11;

   typedef enum logic {
      ST_RUN    = 1'b0,
      ST_SQUASH = 1'b1
   } wb_state_t;

   localparam logic [2:0] STEP_4 = 3'd4;
   localparam logic [2:0] STEP_2 = 3'd2;

endpackage

// File: rtl/rv_wb_squash_ctrl.sv
// rtl/rv_wb_squash_ctrl.sv - squash window FSM following a PC redirect
//
// Purpose: after a redirect is accepted, discards the next SQUASH_CYCLES
//          enabled cycles (the wrong-path instructions already in flight).
// Ports:   clk, rst_n   - clock, asynchronous active-low reset
//          ce           - stage enable; only enabled cycles advance the window
//          change_pc    - redirect taken by the instruction offered this cycle
//          run          - 1 when the stage is accepting instructions
module rv_wb_squash_ctrl
   import rv_pkg::*;
#(
   parameter int SQUASH_CYCLES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic ce,
   input  logic change_pc,
   output logic run
);

   wb_state_t  state, state_next;
   logic [2:0] cnt, cnt_next;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_RUN;
         cnt   <= '0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
      end
   end

   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      case (state)
         ST_RUN: begin
            if (ce && change_pc && (SQUASH_CYCLES > 0)) begin
               state_next = ST_SQUASH;
               cnt_next   = 3'(SQUASH_CYCLES);
            end
         end
         ST_SQUASH: begin
            if (ce) begin
               cnt_next = cnt - 3'd1;
               // <= also recovers from a zero count, which cannot normally occur
               if (cnt <= 3'd1) begin
                  state_next = ST_RUN;
                  cnt_next   = '0;
               end
            end
         end
         default: begin
            state_next = ST_RUN;
            cnt_next   = '0;
         end
      endcase
   end

   assign run = (state == ST_RUN);

endmodule

// File: rtl/rv_writeback_v2.sv
// rtl/rv_writeback_v2.sv - writeback stage: rd select, next PC, retire count
//
// Purpose: selects the destination register value, computes the next PC
//          (sequential, branch/jump, trap, mret), flags misaligned targets,
//          counts retired instructions and squashes wrong-path instructions.
// Ports:   i_clk, i_rst_n              - clock, asynchronous active-low reset
//          i_ce                        - one instruction offered per enabled cycle
//          i_opcode, i_funct3, i_ilen2 - decoded instruction class and fields
//          i_alu_out .. i_csr_out      - operand and result sources
//          i_go_to_trap, i_return_from_trap, i_trap_address, i_return_address
//          o_rd, o_wr_rd               - registered rd value and write enable
//          o_next_pc, o_change_pc      - combinational next PC and redirect flag
//          o_misaligned, o_bad_addr    - misaligned target exception request
//          o_instret, o_ce             - retired count, enable to next stage
module rv_writeback_v2
   import rv_pkg::*;
#(
   parameter int               XLEN          = 32,
   parameter logic [XLEN-1:0]  PC_RESET      = '0,
   parameter int               C_EXT         = 0,
   parameter int               SQUASH_CYCLES = 2
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_ce,
   input  logic [OP_W-1:0]   i_opcode,
   input  logic [2:0]        i_funct3,
   input  logic              i_ilen2,
   input  logic [XLEN-1:0]   i_alu_out,
   input  logic [XLEN-1:0]   i_imm,
   input  logic [XLEN-1:0]   i_rs1,
   input  logic [XLEN-1:0]   i_data_load,
   input  logic [XLEN-1:0]   i_csr_out,
   input  logic              i_go_to_trap,
   input  logic              i_return_from_trap,
   input  logic [XLEN-1:0]   i_trap_address,
   input  logic [XLEN-1:0]   i_return_address,
   output logic [XLEN-1:0]   o_rd,
   output logic              o_wr_rd,
   output logic [XLEN-1:0]   o_next_pc,
   output logic              o_change_pc,
   output logic              o_misaligned,
   output logic [XLEN-1:0]   o_bad_addr,
   output logic [63:0]       o_instret,
   output logic              o_ce
);

   logic [XLEN-1:0] pc, step, seq_pc, base, sum_raw, sum, rd_val;
   logic [63:0]     instret;
   logic            run, taken, misaligned, mis_req, wr_val, wr_final, fire, retire;

   assign step   = ((C_EXT != 0) && i_ilen2) ? XLEN'(STEP_2) : XLEN'(STEP_4);
   assign seq_pc = pc + step;

   // Single adder shared by branch, jal, jalr and auipc.
   assign base    = i_opcode[OP_JALR] ? i_rs1 : pc;
   assign sum_raw = base + i_imm;
   assign sum     = {sum_raw[XLEN-1:1], sum_raw[0] & ~i_opcode[OP_JALR]};

   assign taken      = i_opcode[OP_JAL] | i_opcode[OP_JALR]
                     | (i_opcode[OP_BRANCH] & i_alu_out[0]);
   assign misaligned = taken & ((C_EXT != 0) ? sum[0] : sum[1]);
   // Trap and mret override the jump, so its alignment no longer matters.
   assign mis_req    = misaligned & ~i_go_to_trap & ~i_return_from_trap;

   always_comb begin
      o_next_pc = seq_pc;
      if (i_go_to_trap)            o_next_pc = i_trap_address;
      else if (i_return_from_trap) o_next_pc = i_return_address;
      else if (misaligned)         o_next_pc = pc;
      else if (taken)              o_next_pc = sum;
   end

   always_comb begin
      rd_val = '0;
      wr_val = 1'b0;
      if (i_opcode[OP_RTYPE] | i_opcode[OP_ITYPE]) begin
         rd_val = i_alu_out;
         wr_val = 1'b1;
      end else if (i_opcode[OP_LOAD]) begin
         rd_val = i_data_load;
         wr_val = 1'b1;
      end else if (i_opcode[OP_JAL] | i_opcode[OP_JALR]) begin
         rd_val = seq_pc;
         wr_val = 1'b1;
      end else if (i_opcode[OP_LUI]) begin
         rd_val = i_imm;
         wr_val = 1'b1;
      end else if (i_opcode[OP_AUIPC]) begin
         rd_val = sum;
         wr_val = 1'b1;
      end else if (i_opcode[OP_SYSTEM] && (i_funct3 != 3'd0)) begin
         rd_val = i_csr_out;
         wr_val = 1'b1;
      end
   end

   assign wr_final = wr_val & ~i_go_to_trap & ~i_return_from_trap & ~misaligned;

   assign o_change_pc = run & (o_next_pc != seq_pc);
   assign fire        = i_ce & run;
   assign retire      = ~i_go_to_trap & ~mis_req;

   rv_wb_squash_ctrl #(
      .SQUASH_CYCLES(SQUASH_CYCLES)
   ) u_squash (
      .clk      (i_clk),
      .rst_n    (i_rst_n),
      .ce       (i_ce),
      .change_pc(o_change_pc),
      .run      (run)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         pc           <= PC_RESET;
         o_rd         <= '0;
         o_wr_rd      <= 1'b0;
         o_ce         <= 1'b0;
         o_misaligned <= 1'b0;
         o_bad_addr   <= '0;
         instret      <= '0;
      end else begin
         o_ce         <= i_ce & run;
         o_misaligned <= fire & mis_req;
         if (fire) begin
            pc      <= o_next_pc;
            o_rd    <= rd_val;
            o_wr_rd <= wr_final;
            if (mis_req) o_bad_addr <= sum;
            if (retire)  instret    <= instret + 64'd1;
         end
      end
   end

   assign o_instret = instret;

endmodule

// File: tb/tb_rv_writeback_v2.sv
// tb/tb_rv_writeback_v2.sv - self-checking bench for rv_writeback_v2
module tb_rv_writeback_v2;
   import rv_pkg::*;

   localparam int SQ = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ce, ilen2, trap, mret;
   logic [10:0] opcode;
   logic [2:0]  funct3;
   logic [31:0] alu, imm, rs1, dload, csr, taddr, raddr;

   logic [31:0] o_rd, o_next_pc, o_bad_addr;
   logic        o_wr_rd, o_change_pc, o_misaligned, o_ce;
   logic [63:0] o_instret;
   logic [31:0] c_rd, c_next_pc, c_bad_addr;
   logic        c_wr_rd, c_change_pc, c_misaligned, c_ce;
   logic [63:0] c_instret;

   always #5 clk = ~clk;

   rv_writeback_v2 #(.XLEN(32), .PC_RESET(32'h100), .C_EXT(0), .SQUASH_CYCLES(SQ)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_ce(ce), .i_opcode(opcode), .i_funct3(funct3),
      .i_ilen2(ilen2), .i_alu_out(alu), .i_imm(imm), .i_rs1(rs1), .i_data_load(dload),
      .i_csr_out(csr), .i_go_to_trap(trap), .i_return_from_trap(mret),
      .i_trap_address(taddr), .i_return_address(raddr),
      .o_rd(o_rd), .o_wr_rd(o_wr_rd), .o_next_pc(o_next_pc), .o_change_pc(o_change_pc),
      .o_misaligned(o_misaligned), .o_bad_addr(o_bad_addr), .o_instret(o_instret), .o_ce(o_ce));

   rv_writeback_v2 #(.XLEN(32), .PC_RESET(32'h200), .C_EXT(1), .SQUASH_CYCLES(0)) dut_c (
      .i_clk(clk), .i_rst_n(rst_n), .i_ce(ce), .i_opcode(opcode), .i_funct3(funct3),
      .i_ilen2(ilen2), .i_alu_out(alu), .i_imm(imm), .i_rs1(rs1), .i_data_load(dload),
      .i_csr_out(csr), .i_go_to_trap(trap), .i_return_from_trap(mret),
      .i_trap_address(taddr), .i_return_address(raddr),
      .o_rd(c_rd), .o_wr_rd(c_wr_rd), .o_next_pc(c_next_pc), .o_change_pc(c_change_pc),
      .o_misaligned(c_misaligned), .o_bad_addr(c_bad_addr), .o_instret(c_instret), .o_ce(c_ce));

   int pass_cnt = 0;
   int total    = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Reference model: architectural PC, retired count and remaining discards.
   logic [31:0] m_pc, m_rd, m_bad;
   logic        m_wr, m_mis, m_oce;
   logic [63:0] m_instret;
   int          m_discard;
   logic [31:0] p_npc, p_rd, p_sum;
   logic        p_chg, p_wr, p_mis;

   task automatic model_reset();
      m_pc = 32'h100; m_rd = 0; m_bad = 0; m_wr = 0; m_mis = 0; m_oce = 0;
      m_instret = 0; m_discard = 0;
   endtask

   task automatic set_idle();
      ce = 0; ilen2 = 0; trap = 0; mret = 0; opcode = 0; funct3 = 0;
      alu = 0; imm = 0; rs1 = 0; dload = 0; csr = 0; taddr = 0; raddr = 0;
   endtask

   task automatic predict();
      logic [31:0] seq, tgt;
      logic taken, bad;
      int cls;
      cls = -1;
      for (int i = 0; i < 11; i++) if (opcode[i]) cls = i;
      seq = m_pc + 32'd4;
      tgt = ((cls == 6) ? rs1 : m_pc) + imm;
      if (cls == 6) tgt[0] = 1'b0;
      taken = (cls == 5) || (cls == 6) || (cls == 4 && alu[0]);
      bad = taken && tgt[1];
      p_rd = 0; p_wr = 0;
      case (cls)
         0, 1: begin p_rd = alu;   p_wr = 1; end
         2:    begin p_rd = dload; p_wr = 1; end
         5, 6: begin p_rd = seq;   p_wr = 1; end
         7:    begin p_rd = imm;   p_wr = 1; end
         8:    begin p_rd = tgt;   p_wr = 1; end
         9:    if (funct3 != 0) begin p_rd = csr; p_wr = 1; end
         default: ;
      endcase
      if (trap)       p_npc = taddr;
      else if (mret)  p_npc = raddr;
      else if (bad)   p_npc = m_pc;
      else if (taken) p_npc = tgt;
      else            p_npc = seq;
      p_wr  = p_wr && !trap && !mret && !bad;
      p_mis = bad && !trap && !mret;
      p_chg = (m_discard == 0) && (p_npc != seq);
      p_sum = tgt;
   endtask

   task automatic model_update();
      m_oce = ce && (m_discard == 0);
      m_mis = 1'b0;
      if (ce) begin
         if (m_discard > 0) m_discard--;
         else begin
            m_pc = p_npc; m_rd = p_rd; m_wr = p_wr;
            if (!trap && !p_mis) m_instret++;
            if (p_mis) begin m_mis = 1'b1; m_bad = p_sum; end
            if (p_chg) m_discard = SQ;
         end
      end
   endtask

   // Inputs already driven just after a falling edge; ends on the next one.
   task automatic run_cycle();
      #1;
      predict();
      chk("next_pc", o_next_pc, p_npc);
      chk("change_pc", o_change_pc, p_chg);
      @(posedge clk); #1;
      model_update();
      chk("pc", dut.pc, m_pc);
      chk("wr_rd", o_wr_rd, m_wr);
      chk("instret", o_instret, m_instret);
      chk("o_ce", o_ce, m_oce);
      chk("misaligned", o_misaligned, m_mis);
      if (m_wr) chk("rd", o_rd, m_rd);
      if (m_mis) chk("bad_addr", o_bad_addr, m_bad);
      @(negedge clk);
   endtask

   task automatic do_reset();
      set_idle();
      rst_n = 0;
      @(posedge clk); #1;
      @(negedge clk);
      rst_n = 1;
      model_reset();
   endtask

   typedef struct {
      logic [10:0] op;  logic [2:0] f3;
      logic [31:0] alu, imm, rs1, dl, csr;
      logic        tr, mr;
      logic [31:0] ta, ra;
      logic [31:0] e_npc, e_pc, e_rd, e_bad;
      logic        e_wr, e_mis;
      logic [63:0] e_ir;
   } vec_t;

   function automatic vec_t mk(input int opbit, input logic [2:0] f3, input logic [31:0] a,
                               input logic [31:0] im, input logic [31:0] r1, input logic [31:0] dl,
                               input logic [31:0] cs, input logic tr, input logic mr,
                               input logic [31:0] ta, input logic [31:0] ra,
                               input logic [31:0] e_npc, input logic [31:0] e_pc,
                               input logic [31:0] e_rd, input logic e_wr, input logic e_mis,
                               input logic [31:0] e_bad, input logic [63:0] e_ir);
      vec_t v;
      v.op = 11'd1 << opbit; v.f3 = f3; v.alu = a; v.imm = im; v.rs1 = r1; v.dl = dl;
      v.csr = cs; v.tr = tr; v.mr = mr; v.ta = ta; v.ra = ra; v.e_npc = e_npc; v.e_pc = e_pc;
      v.e_rd = e_rd; v.e_wr = e_wr; v.e_mis = e_mis; v.e_bad = e_bad; v.e_ir = e_ir;
      return v;
   endfunction

   vec_t vt[16];

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      // Each vector starts from reset: pc=0x100, instret=0.
      //          op f3 alu     imm           rs1     dl     csr    tr mr ta     ra     npc    pc     rd           wr mis bad    ir
      vt[0]  = mk(1, 0, 5,     0,           0,      0,     0,     0, 0, 0,     0,     'h104, 'h104, 5,           1, 0, 0,     1);
      vt[1]  = mk(5, 0, 0,     'h20,        0,      0,     0,     0, 0, 0,     0,     'h120, 'h120, 'h104,       1, 0, 0,     1);
      vt[2]  = mk(6, 0, 0,     0,           'h302,  0,     0,     0, 0, 0,     0,     'h100, 'h100, 0,           0, 1, 'h302, 0);
      vt[3]  = mk(1, 0, 7,     0,           0,      0,     0,     1, 1, 'h40,  'h80,  'h40,  'h40,  0,           0, 0, 0,     0);
      vt[4]  = mk(1, 0, 7,     0,           0,      0,     0,     0, 1, 'h40,  'h80,  'h80,  'h80,  0,           0, 0, 0,     1);
      vt[5]  = mk(7, 0, 0,     'h12345000,  0,      0,     0,     0, 0, 0,     0,     'h104, 'h104, 'h12345000,  1, 0, 0,     1);
      vt[6]  = mk(8, 0, 0,     'h1000,      0,      0,     0,     0, 0, 0,     0,     'h104, 'h104, 'h1100,      1, 0, 0,     1);
      vt[7]  = mk(4, 0, 1,     'h10,        0,      0,     0,     0, 0, 0,     0,     'h110, 'h110, 0,           0, 0, 0,     1);
      vt[8]  = mk(4, 0, 0,     'h10,        0,      0,     0,     0, 0, 0,     0,     'h104, 'h104, 0,           0, 0, 0,     1);
      vt[9]  = mk(9, 0, 0,     0,           0,      0,     'habc, 0, 0, 0,     0,     'h104, 'h104, 0,           0, 0, 0,     1);
      vt[10] = mk(9, 2, 0,     0,           0,      0,     'habc, 0, 0, 0,     0,     'h104, 'h104, 'habc,       1, 0, 0,     1);
      vt[11] = mk(2, 0, 0,     0,           0,      'h55,  0,     0, 0, 0,     0,     'h104, 'h104, 'h55,        1, 0, 0,     1);
      vt[12] = mk(3, 0, 0,     0,           0,      0,     0,     0, 0, 0,     0,     'h104, 'h104, 0,           0, 0, 0,     1);
      vt[13] = mk(6, 0, 0,     'h10,        'h201,  0,     0,     0, 0, 0,     0,     'h210, 'h210, 'h104,       1, 0, 0,     1);
      vt[14] = mk(10, 0, 0,    0,           0,      0,     0,     0, 0, 0,     0,     'h104, 'h104, 0,           0, 0, 0,     1);
      vt[15] = mk(4, 0, 1,     'h6,         0,      0,     0,     0, 0, 0,     0,     'h100, 'h100, 0,           0, 1, 'h106, 0);

      set_idle();
      @(negedge clk);
      do_reset();
      chk("rst_pc", dut.pc, 32'h100);
      chk("rst_rd", o_rd, 0);
      chk("rst_wr_rd", o_wr_rd, 0);
      chk("rst_o_ce", o_ce, 0);
      chk("rst_misaligned", o_misaligned, 0);
      chk("rst_bad_addr", o_bad_addr, 0);
      chk("rst_instret", o_instret, 0);

      for (int k = 0; k < 16; k++) begin
         do_reset();
         opcode = vt[k].op; funct3 = vt[k].f3; alu = vt[k].alu; imm = vt[k].imm;
         rs1 = vt[k].rs1; dload = vt[k].dl; csr = vt[k].csr; trap = vt[k].tr;
         mret = vt[k].mr; taddr = vt[k].ta; raddr = vt[k].ra; ce = 1;
         #1;
         chk($sformatf("v%0d_next_pc", k), o_next_pc, vt[k].e_npc);
         chk($sformatf("v%0d_change_pc", k), o_change_pc, vt[k].e_npc != 32'h104);
         @(posedge clk); #1;
         chk($sformatf("v%0d_pc", k), dut.pc, vt[k].e_pc);
         chk($sformatf("v%0d_wr_rd", k), o_wr_rd, vt[k].e_wr);
         chk($sformatf("v%0d_instret", k), o_instret, vt[k].e_ir);
         chk($sformatf("v%0d_misaligned", k), o_misaligned, vt[k].e_mis);
         if (vt[k].e_wr)  chk($sformatf("v%0d_rd", k), o_rd, vt[k].e_rd);
         if (vt[k].e_mis) chk($sformatf("v%0d_bad_addr", k), o_bad_addr, vt[k].e_bad);
         @(negedge clk);
         set_idle();
         @(posedge clk); #1;
         if (vt[k].e_mis) chk($sformatf("v%0d_mis_one_cycle", k), o_misaligned, 0);
         @(negedge clk);
      end

      // jal then squash window; an idle cycle must not shorten it.
      do_reset();
      opcode = 11'd1 << OP_JAL; imm = 32'h20; ce = 1;
      run_cycle();
      chk("sq_jal_rd", o_rd, 32'h104);
      chk("sq_jal_pc", dut.pc, 32'h120);
      set_idle(); opcode = 11'd1 << OP_ITYPE; alu = 9;
      run_cycle();
      for (int i = 0; i < 2; i++) begin
         ce = 1;
         run_cycle();
         chk("sq_discard_o_ce", o_ce, 0);
         chk("sq_discard_pc", dut.pc, 32'h120);
         chk("sq_discard_instret", o_instret, 1);
      end
      run_cycle();
      chk("sq_resume_pc", dut.pc, 32'h124);
      chk("sq_resume_instret", o_instret, 2);
      chk("sq_resume_o_ce", o_ce, 1);

      // Reset asserted while squashing.
      do_reset();
      opcode = 11'd1 << OP_JAL; imm = 32'h20; ce = 1;
      run_cycle();
      chk("rsq_in_squash", dut.u_squash.state, ST_SQUASH);
      rst_n = 0;
      #1;
      chk("rsq_state", dut.u_squash.state, ST_RUN);
      chk("rsq_pc", dut.pc, 32'h100);
      chk("rsq_rd", o_rd, 0);
      chk("rsq_wr_rd", o_wr_rd, 0);
      chk("rsq_o_ce", o_ce, 0);
      chk("rsq_instret", o_instret, 0);
      @(posedge clk); #1;
      @(negedge clk);
      rst_n = 1;
      model_reset();
      set_idle(); opcode = 11'd1 << OP_ITYPE; alu = 3; ce = 1;
      run_cycle();
      chk("rsq_after_pc", dut.pc, 32'h104);
      chk("rsq_after_o_ce", o_ce, 1);

      // instret wrap at 2^64.
      do_reset();
      force dut.instret = 64'hFFFF_FFFF_FFFF_FFFF;
      #1;
      release dut.instret;
      #1;
      chk("wrap_preload", o_instret, 64'hFFFF_FFFF_FFFF_FFFF);
      m_instret = 64'hFFFF_FFFF_FFFF_FFFF;
      opcode = 11'd1 << OP_ITYPE; alu = 1; ce = 1;
      run_cycle();
      chk("wrap_zero", o_instret, 0);

      // Compressed-step instance: PC_RESET=0x200, C_EXT=1.
      do_reset();
      opcode = 11'd1 << OP_ITYPE; ilen2 = 1; ce = 1;
      #1;
      chk("c_next_pc_step2", c_next_pc, 32'h202);
      chk("c_change_pc", c_change_pc, 0);
      @(posedge clk); #1;
      chk("c_pc", dut_c.pc, 32'h202);
      @(negedge clk);
      opcode = 11'd1 << OP_BRANCH; alu = 1; imm = 3;
      #1;
      chk("c_mis_next_pc", c_next_pc, 32'h202);
      @(posedge clk); #1;
      chk("c_misaligned", c_misaligned, 1);
      chk("c_bad_addr", c_bad_addr, 32'h205);
      chk("c_pc_held", dut_c.pc, 32'h202);
      @(negedge clk);

      // Random stimulus against the model.
      do_reset();
      for (int n = 0; n < 400; n++) begin
         ce     = ($urandom_range(0, 3) != 0);
         opcode = 11'd1 << $urandom_range(0, 10);
         funct3 = 3'($urandom_range(0, 7));
         ilen2  = 1'($urandom_range(0, 1));
         alu    = $urandom;
         imm    = 32'($urandom_range(0, 127)) << 1;
         rs1    = $urandom;
         dload  = $urandom;
         csr    = $urandom;
         trap   = ($urandom_range(0, 15) == 0);
         mret   = ($urandom_range(0, 15) == 0);
         taddr  = $urandom & ~32'h3;
         raddr  = $urandom & ~32'h3;
         run_cycle();
      end

      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule

// File: doc/rv_writeback_v2.md
RV_WRITEBACK_V2 -- requirements
Module: rv_writeback_v2

Interface
REQ-001 Parameter XLEN, default 32, datapath and PC width (32 or 64).
REQ-002 Parameter PC_RESET, default 0, PC value loaded on reset.
REQ-003 Parameter C_EXT, default 0, 1 enables 2-byte instruction alignment and step.
REQ-004 Parameter SQUASH_CYCLES, default 2, range 0..7, enabled cycles discarded after a redirect.
REQ-005 i_clk input 1: clock.
REQ-006 i_rst_n input 1: asynchronous, active-low reset.
REQ-007 i_ce input 1: stage clock enable; one instruction offered per asserted cycle.
REQ-008 i_opcode input 11: one-hot class, bits [10:0] are fence, system, auipc, lui, jalr, jal, branch, store, load, itype, rtype.
REQ-009 i_funct3 input 3: function field.
REQ-010 i_ilen2 input 1: instruction is 2 bytes; ignored when C_EXT=0.
REQ-011 i_alu_out, i_imm, i_rs1, i_data_load, i_csr_out inputs XLEN: ALU result, immediate, rs1, load data, CSR read data.
REQ-012 i_go_to_trap, i_return_from_trap inputs 1: trap entry, mret.
REQ-013 i_trap_address, i_return_address inputs XLEN: mtvec, mepc.
REQ-014 o_rd output XLEN: registered rd value; o_wr_rd output 1: registered rd write enable.
REQ-015 o_next_pc output XLEN: combinational next PC; o_change_pc output 1: combinational redirect flag.
REQ-016 o_misaligned output 1: registered single-cycle misaligned-target exception request; o_bad_addr output XLEN: offending target.
REQ-017 o_instret output 64: retired-instruction count; o_ce output 1: registered enable to next stage.

Function
REQ-018 Step = 2 when C_EXT=1 and i_ilen2=1, else 4; seq_pc = pc + step, modulo 2^XLEN.
REQ-019 One shared adder computes (jalr ? i_rs1 : pc) + i_imm; for jalr, bit 0 of the result is cleared.
REQ-020 Priority: i_go_to_trap > i_return_from_trap > normal; trap and mret set next PC to i_trap_address / i_return_address, wr_rd=0.
REQ-021 Normal rd source: rtype/itype alu_out; load data_load; jal/jalr seq_pc; lui imm; auipc sum; system with funct3!=0 csr_out.
REQ-022 wr_rd=0 for branch, store, fence, and system with funct3=0; otherwise 1.
REQ-023 Branch is taken when i_alu_out[0]=1 and sets next PC to sum; jal/jalr set next PC to sum.
REQ-024 A target is misaligned when bit1=1 (C_EXT=0) or bit0=1 (C_EXT=1); on a taken misaligned target: PC is held, wr_rd=0, o_misaligned=1 for one cycle, o_bad_addr=target, not retired.
REQ-025 o_change_pc = (next PC != seq_pc) in RUN; it is 0 in SQUASH.
REQ-026 FSM RUN/SQUASH; RUN->SQUASH on an i_ce cycle with o_change_pc=1 and SQUASH_CYCLES>0; counter loads SQUASH_CYCLES.
REQ-027 In SQUASH, each i_ce cycle decrements the counter and discards its instruction (no pc/rd/wr_rd/instret update, trap inputs ignored); at 1->0 the FSM returns to RUN.
REQ-028 pc, o_rd, o_wr_rd and o_instret update only on i_ce in RUN; with i_ce=0 all state holds.
REQ-029 o_instret increments by 1 per non-trap, non-misaligned i_ce cycle in RUN (mret counts) and wraps at 2^64 to 0.
REQ-030 o_ce <= i_ce & (state==RUN) each cycle.

Reset
REQ-031 While i_rst_n=0: pc=PC_RESET, o_rd=0, o_wr_rd=0, o_ce=0, o_misaligned=0, o_bad_addr=0, o_instret=0, state=RUN, counter=0; reset mid-SQUASH aborts the squash.

Structure
REQ-032 The opcode bit indices, FSM state encoding and step constants SHALL reside in the shared package rv_pkg.
REQ-033 The squash FSM and counter SHALL be one sub-module, rv_wb_squash_ctrl; all other logic is inline.

Verification
REQ-034 Reset PC_RESET=0x100, then an itype with alu_out=5 on i_ce -> o_rd=5, o_wr_rd=1, pc=0x104, o_instret=1.
REQ-035 jal at pc=0x100, imm=0x20, SQUASH_CYCLES=2 -> o_rd=0x104, next PC 0x120, the following two i_ce instructions are discarded, o_ce=0 for those cycles.
REQ-036 C_EXT=1, i_ilen2=1 at pc=0x200 -> next PC 0x202; C_EXT=0, jalr to rs1=0x302, imm=0 -> o_misaligned=1, o_bad_addr=0x302, pc held.
REQ-037 i_go_to_trap and i_return_from_trap both set, mtvec=0x40 -> next PC 0x40, o_wr_rd=0, instret unchanged.
REQ-038 Force o_instret to 0xFFFF_FFFF_FFFF_FFFF, retire one instruction -> o_instret=0; assert reset during SQUASH -> state RUN, all outputs at reset values.
